// File: rtl/ps2_arrow_tracker.sv
`default_nettype none
// ============================================================================
// Module   : ps2_arrow_tracker
// Purpose  : Parses the raw PS/2 byte stream (E0 extended and F0 break
//            prefixes) and tracks the four arrow keys. It produces held
//            state, one-cycle press/release pulses, typematic repeat pulses
//            for the most recently pressed key, and an abort pulse when a
//            prefix sequence stalls.
// Ports    : clk         - single clock
//            rst         - synchronous active-high reset
//            data_i      - PS/2 byte from the receiver
//            valid_i     - one-cycle strobe; data_i is consumed when high
//            held_o      - key-down state {right, left, down, up}
//            press_o     - one-cycle pulse on held 0->1
//            release_o   - one-cycle pulse on held 1->0
//            rpt_o       - one-cycle typematic repeat pulse
//            last_code_o - {8'hE0, code} of the last completed arrow event
//            abort_o     - one-cycle pulse when a prefix sequence times out
// Macro    : PS2_ARROW_TRACKER_TYPEMATIC_EN - builds the repeat logic; when
//            undefined rpt_o is tied to 0.
// Revision : 1.0 - initial release
// ============================================================================
module ps2_arrow_tracker #(
  parameter int DELAY_CYC   = 16,
  parameter int PERIOD_CYC  = 4,
  parameter int TIMEOUT_CYC = 64,
  parameter int CNT_W       = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  data_i,
  input  logic        valid_i,
  output logic [3:0]  held_o,
  output logic [3:0]  press_o,
  output logic [3:0]  release_o,
  output logic [3:0]  rpt_o,
  output logic [15:0] last_code_o,
  output logic        abort_o
);

  localparam logic [CNT_W-1:0] DELAY_LD  = CNT_W'(DELAY_CYC);
  localparam logic [CNT_W-1:0] PERIOD_LD = CNT_W'(PERIOD_CYC);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXT     = 2'd1,
    EXT_BRK = 2'd2,
    BRK     = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  to_q, to_d;
  logic              abort_q, abort_d;
  logic [3:0]        held_q, held_d;
  logic [3:0]        press_q, press_d;
  logic [3:0]        release_q, release_d;
  logic [15:0]       last_code_q, last_code_d;

  logic              w_is_arrow;
  logic [1:0]        w_key_idx;
  logic [3:0]        w_key_oh;
  logic              w_mk;
  logic              w_brk;
  logic              w_new_press;
  logic              w_new_release;

  // Arrow scancode to key index: 0=up, 1=down, 2=left, 3=right.
  always_comb begin
    w_is_arrow = 1'b1;
    w_key_idx  = 2'd0;
    case (data_i)
      8'h75:   w_key_idx = 2'd0;
      8'h72:   w_key_idx = 2'd1;
      8'h6B:   w_key_idx = 2'd2;
      8'h74:   w_key_idx = 2'd3;
      default: w_is_arrow = 1'b0;
    endcase
  end

  assign w_key_oh = 4'b0001 << w_key_idx;

  // Prefix parser and idle timeout. The timeout counter only advances on
  // idle cycles in a non-IDLE state, so a byte arriving on the cycle the
  // count would expire takes priority over the abort.
  always_comb begin
    state_d = state_q;
    to_d    = to_q;
    abort_d = 1'b0;
    w_mk    = 1'b0;
    w_brk   = 1'b0;
    if (valid_i) begin
      to_d = '0;
      case (state_q)
        IDLE: begin
          if (data_i == 8'hE0)      state_d = EXT;
          else if (data_i == 8'hF0) state_d = BRK;
        end
        EXT: begin
          if (data_i == 8'hF0) begin
            state_d = EXT_BRK;
          end else if (data_i != 8'hE0) begin
            state_d = IDLE;
            w_mk    = w_is_arrow;
          end
        end
        EXT_BRK: begin
          state_d = IDLE;
          w_brk   = w_is_arrow;
        end
        default: state_d = IDLE;  // BRK: discard the non-extended code
      endcase
    end else if (state_q != IDLE) begin
      if (to_q == TO_LAST) begin
        state_d = IDLE;
        abort_d = 1'b1;
        to_d    = '0;
      end else begin
        to_d = to_q + CNT_W'(1);
      end
    end
  end

  assign w_new_press   = w_mk  & ~held_q[w_key_idx];
  assign w_new_release = w_brk &  held_q[w_key_idx];

  // Key state; last_code updates on every completed arrow event, including
  // device re-makes and breaks of keys that were not held.
  always_comb begin
    held_d      = held_q;
    press_d     = '0;
    release_d   = '0;
    last_code_d = last_code_q;
    if (w_mk || w_brk) begin
      last_code_d = {8'hE0, data_i};
    end
    if (w_new_press) begin
      held_d  = held_q | w_key_oh;
      press_d = w_key_oh;
    end
    if (w_new_release) begin
      held_d    = held_q & ~w_key_oh;
      release_d = w_key_oh;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      to_q        <= '0;
      abort_q     <= 1'b0;
      held_q      <= '0;
      press_q     <= '0;
      release_q   <= '0;
      last_code_q <= '0;
    end else begin
      state_q     <= state_d;
      to_q        <= to_d;
      abort_q     <= abort_d;
      held_q      <= held_d;
      press_q     <= press_d;
      release_q   <= release_d;
      last_code_q <= last_code_d;
    end
  end

`ifdef PS2_ARROW_TRACKER_TYPEMATIC_EN
  logic             act_vld_q, act_vld_d;
  logic [1:0]       act_idx_q, act_idx_d;
  logic [CNT_W-1:0] rcnt_q, rcnt_d;
  logic [3:0]       rpt_q, rpt_d;

  // Repeat timer for the active key. A new press or the release of the
  // active key overrides a coincident expiry, suppressing that rpt.
  always_comb begin
    act_vld_d = act_vld_q;
    act_idx_d = act_idx_q;
    rcnt_d    = rcnt_q;
    rpt_d     = '0;
    if (act_vld_q) begin
      if (rcnt_q == CNT_W'(1)) begin
        rpt_d  = 4'b0001 << act_idx_q;
        rcnt_d = PERIOD_LD;
      end else begin
        rcnt_d = rcnt_q - CNT_W'(1);
      end
    end
    if (w_new_press) begin
      act_vld_d = 1'b1;
      act_idx_d = w_key_idx;
      rcnt_d    = DELAY_LD;
      rpt_d     = '0;
    end else if (w_new_release && act_vld_q && (act_idx_q == w_key_idx)) begin
      act_vld_d = 1'b0;
      rcnt_d    = '0;
      rpt_d     = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      act_vld_q <= 1'b0;
      act_idx_q <= 2'd0;
      rcnt_q    <= '0;
      rpt_q     <= '0;
    end else begin
      act_vld_q <= act_vld_d;
      act_idx_q <= act_idx_d;
      rcnt_q    <= rcnt_d;
      rpt_q     <= rpt_d;
    end
  end

  assign rpt_o = rpt_q;
`else
  logic unused_cfg;
  assign unused_cfg = ^{DELAY_LD, PERIOD_LD};
  assign rpt_o      = '0;
`endif

  assign held_o      = held_q;
  assign press_o     = press_q;
  assign release_o   = release_q;
  assign last_code_o = last_code_q;
  assign abort_o     = abort_q;

endmodule
`default_nettype wire

// File: doc/ps2_arrow_tracker.md
Name: ps2_arrow_tracker

Overview:
Sequential successor to the combinational arrow-key decoder. It consumes the raw PS/2 byte stream from the PS/2 receiver and parses E0 (extended) and F0 (break) prefixes with a small FSM. It tracks the held state of the four arrow keys and emits one-cycle press and release pulses. It also generates parametrised typematic repeat pulses for the most recently pressed key. It sits between the PS/2 receiver and game/UI logic.

Parameters:
- DELAY_CYC, 16, cycles from press to the first repeat pulse (>=1).
- PERIOD_CYC, 4, cycles between subsequent repeat pulses (>=1).
- TIMEOUT_CYC, 64, max idle cycles allowed inside a prefix sequence before abort (>=1).
- CNT_W, 16, width of the repeat and timeout counters; must hold max(DELAY_CYC, PERIOD_CYC, TIMEOUT_CYC).

Ports:
- clk, input, 1, single clock.
- rst, input, 1, synchronous, active-high reset.
- data, input, 8, PS/2 byte from receiver.
- valid, input, 1, one-cycle strobe; data is consumed when valid=1.
- held, output, 4, key-down state; bit0=up, bit1=down, bit2=left, bit3=right.
- press, output, 4, one-cycle pulse on the held 0->1 transition.
- release, output, 4, one-cycle pulse on the held 1->0 transition.
- rpt, output, 4, one-cycle typematic pulse.
- last_code, output, 16, scancode of the last completed arrow event: {8'hE0, code}.
- abort, output, 1, one-cycle pulse when a prefix sequence times out.

Behaviour:
- Reset (synchronous, active-high, clk rising edge): all outputs 0. FSM = IDLE. Counters = 0. No active repeat key.
- Codes: up=E0 75, down=E0 72, left=E0 6B, right=E0 74. Make = E0 xx. Break = E0 F0 xx.
- FSM states: IDLE, EXT, EXT_BRK, BRK.
  - IDLE: E0 -> EXT. F0 -> BRK. Any other byte -> IDLE, ignored.
  - EXT: F0 -> EXT_BRK. E0 -> EXT (duplicate prefix tolerated). Arrow code -> make event, then IDLE. Any other byte -> IDLE, ignored.
  - EXT_BRK: arrow code -> break event, then IDLE. Any other byte -> IDLE, ignored.
  - BRK: non-extended break; the next byte is discarded, then IDLE.
- Timeout: in any non-IDLE state, a counter increments each cycle with valid=0 and clears on valid. When it reaches TIMEOUT_CYC: go to IDLE, pulse abort for one cycle. If valid is high in the same cycle the count would reach TIMEOUT_CYC, the byte wins and there is no abort.
- Event latency: outputs update on the clock edge that consumes the final byte. held, press, release and last_code are visible the cycle after valid.
- Make for key k:
  - If held[k]=0: set held[k], pulse press[k], update last_code, make k the active repeat key, load the repeat counter with DELAY_CYC.
  - If held[k]=1 (device typematic re-make): no press pulse, no change to the repeat counter or active key; last_code still updates.
- Break for key k:
  - If held[k]=1: clear held[k], pulse release[k], update last_code. If k is the active key, clear the active key and stop the counter.
  - If held[k]=0: no pulse; last_code still updates.
- Repeat: while an active key exists, the counter decrements each cycle. At 1 -> pulse rpt[active] next cycle and reload PERIOD_CYC. First rpt comes exactly DELAY_CYC cycles after the press pulse; subsequent rpt pulses every PERIOD_CYC cycles.
- Collisions:
  - Release of the active key in the same cycle as repeat expiry: release wins, no rpt.
  - New press in the same cycle as expiry: the new key becomes active, no rpt for the old key.
- Releasing a non-active key leaves repeat untouched.
- Invariants: at most one rpt bit set per cycle. press/release/rpt never coincide on the same bit.

Optional Feature:
- Macro: PS2_ARROW_TRACKER_TYPEMATIC_EN.
- Defined: repeat logic as above.
- Undefined: rpt tied to 0. Repeat counter and active-key register are not built. All other behaviour is identical.

Test Plan:
- Reset, then bytes E0,75 -> next cycle held=4'b0001, press=4'b0001 for 1 cycle, last_code=16'hE075.
- With up held, bytes E0,F0,75 -> held=0, release=4'b0001 for 1 cycle, last_code=16'hE075; with the macro defined, no further rpt.
- Macro defined, DELAY_CYC=16, PERIOD_CYC=4: press right, hold -> rpt=4'b1000 at 16 cycles after press, then at 20, 24, 28.
- Press left then down, release left -> rpt continues only on bit1 (down) from down's press timing; left release gives no rpt change.
- Byte E0, then 64 idle cycles -> abort pulses once, FSM returns to IDLE; a following 75 alone leaves held unchanged.
- Non-arrow traffic F0,1C then E0,12 -> no outputs change; repeated E0,6B while left held -> no second press pulse.
